instr_fetch: RTL

//  Instruction fetch unit: produces the 32-bit instruction word that the decode/control stage consumes.
//  - Owns the PC and drives a synchronous-read instruction memory (1-cycle read latency).
//  - Buffers returned words in a 2-entry FIFO and presents them downstream with a valid/ready handshake.
//  - Accepts a PC redirect that flushes all buffered and in-flight fetches.

---
 rtl/instr_fetch.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit.
// Owns the PC, issues reads to a synchronous (1-cycle latency) instruction
// memory, buffers returned words in a 2-entry FIFO and hands them to decode
// over a valid/ready handshake. A redirect flushes everything buffered or in
// flight and restarts fetching at the new target.
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  // Instruction addresses are always word aligned; the low two bits of any
  // incoming target are simply masked off.
  localparam logic [ADDR_W-1:0] ALIGN_MASK       = ~(ADDR_W'(3));
  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;
  localparam logic [ADDR_W-1:0] PC_STEP          = ADDR_W'(4);

  // RUN issues requests while FIFO credit remains; HOLD parks the fetcher
  // when buffered plus in-flight words already fill both FIFO slots.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;

  // One outstanding memory read at most: its address and the epoch it was
  // issued under travel alongside so a stale reply can be recognised.
  logic              inflight_q, inflight_d;
  logic              inflight_epoch_q, inflight_epoch_d;
  logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;
  logic              epoch_q, epoch_d;

  // Two-entry circular FIFO of fetched words and their addresses.
  logic [1:0][31:0]       fifo_data_q, fifo_data_d;
  logic [1:0][ADDR_W-1:0] fifo_pc_q, fifo_pc_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [1:0]             occ_q, occ_d;

  logic       pop;
  logic       push;
  logic [2:0] pending;
  logic [2:0] committed;
  logic       can_issue;

  // Handshake, credit accounting and the memory request for this cycle.
  always_comb begin
    instr_valid = (occ_q != 2'd0);
    pop         = instr_valid & instr_ready;
    push        = inflight_q & (inflight_epoch_q == epoch_q) & ~redirect_valid;
    committed   = {1'b0, occ_q} + {2'b00, inflight_q};
    pending     = committed - {2'b00, pop};
    can_issue   = 1'b0;
    if (state_q == RUN) begin
      can_issue = (pending < 3'd2);
    end else begin
      can_issue = pop;
    end
    imem_req  = ~rst & ~redirect_valid & can_issue;
    imem_addr = pc_q;
    instr     = instr_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    instr_pc  = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
  end

  // PC advance, redirect target load and in-flight tracking.
  always_comb begin
    pc_d             = pc_q;
    epoch_d          = epoch_q;
    inflight_d       = imem_req;
    inflight_epoch_d = epoch_q;
    inflight_addr_d  = inflight_addr_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ALIGN_MASK;
      epoch_d = ~epoch_q;
    end else if (imem_req) begin
      pc_d            = pc_q + PC_STEP;
      inflight_addr_d = pc_q;
    end
  end

  // FIFO write of returning words, read-side advance on pop, flush on redirect.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    if (redirect_valid) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (push) begin
        fifo_data_d[wr_ptr_q] = imem_rdata;
        fifo_pc_d[wr_ptr_q]   = inflight_addr_q;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // RUN/HOLD next-state: park when credit is exhausted, resume on a pop.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if ((committed == 3'd2) && !pop) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (pop) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      pc_q             <= RESET_PC_ALIGNED;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      inflight_addr_q  <= '0;
      epoch_q          <= 1'b0;
      rd_ptr_q         <= 1'b0;
      wr_ptr_q         <= 1'b0;
      occ_q            <= 2'd0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      inflight_addr_q  <= inflight_addr_d;
      epoch_q          <= epoch_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      occ_q            <= occ_d;
    end
  end

  // FIFO storage; cleared on reset so nothing from before reset can resurface.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_data_q <= '0;
      fifo_pc_q   <= '0;
    end else begin
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

endmodule
